// File: rtl/aes_pkg.sv
// Shared AES constants: round count, Rcon table, S-box table and key-expander FSM state type.
// Pure constants and combinational helpers; no latency.
// No flow control; consumed by the key expander and the round datapath.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    // Expander FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_EXPAND = 1'b1;

    // Entry i is the Rcon byte used to build round i+1
    localparam logic [0:9][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, shared with the SubBytes stage of the round datapath
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rcon byte for the round following round idx; zero once the schedule is exhausted
    function automatic logic [7:0] rcon_next(input logic [3:0] idx);
        return (idx < NR) ? RCON[idx] : 8'h00;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-expander request/round-key stream bundle; master = key consumer/controller, slave = expander.
// Wires only; no latency.
// Round keys flow under oKeyValid/iKeyReady; readback port exists only with AES_KEY_BUFFER_EN.
interface aes_key_expand_if;
    logic         iStart;
    logic [127:0] iKey;
    logic         iKeyReady;
    logic [127:0] oRoundKey;
    logic [3:0]   oRoundIdx;
    logic         oKeyValid;
    logic         oFinalRound;
    logic         oBusy;
`ifdef AES_KEY_BUFFER_EN
    logic [3:0]   iRdIdx;
    logic [127:0] oRdKey;

    modport master (output iStart, iKey, iKeyReady, iRdIdx,
                    input  oRoundKey, oRoundIdx, oKeyValid, oFinalRound, oBusy, oRdKey);
    modport slave  (input  iStart, iKey, iKeyReady, iRdIdx,
                    output oRoundKey, oRoundIdx, oKeyValid, oFinalRound, oBusy, oRdKey);
`else
    modport master (output iStart, iKey, iKeyReady,
                    input  oRoundKey, oRoundIdx, oKeyValid, oFinalRound, oBusy);
    modport slave  (input  iStart, iKey, iKeyReady,
                    output oRoundKey, oRoundIdx, oKeyValid, oFinalRound, oBusy);
`endif
endinterface

// File: rtl/aes_sub_word.sv
// 32-bit SubWord: four parallel S-box lookups.
// Purely combinational, zero latency.
// No flow control.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] iWord,
    output logic [31:0] oWord
);

    assign oWord = {sbox(iWord[31:24]), sbox(iWord[23:16]),
                    sbox(iWord[15:8]),  sbox(iWord[7:0])};

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule streamer: emits round keys 0..10 one per accepted handshake (optional bank: AES_KEY_BUFFER_EN).
// Round 0 valid one cycle after start; each further round one cycle after its predecessor's handshake.
// Holds key/index/valid stable while iKeyReady is low; starts are ignored until back in IDLE.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst_n,
    aes_key_expand_if.slave  bus
);

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   idx_q, idx_d;
    logic         load_en;
    logic         vld;
    logic         hs;

    logic [31:0]  w0, w1, w2, w3, rot_w3, sub_w3;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;

    // Valid is exactly "expansion in progress"; busy covers the same window
    assign vld = (state_q == ST_EXPAND);
    assign hs  = vld && bus.iKeyReady;

    assign w0     = key_q[127:96];
    assign w1     = key_q[95:64];
    assign w2     = key_q[63:32];
    assign w3     = key_q[31:0];
    assign rot_w3 = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .iWord (rot_w3),
        .oWord (sub_w3)
    );

    assign n0       = w0 ^ sub_w3 ^ {rcon_next(idx_q), 24'h000000};
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // Next-state: start only from IDLE, advance one round per handshake, leave after round 10
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        load_en = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus.iStart) begin
                key_d   = bus.iKey;
                idx_d   = 4'd0;
                load_en = 1'b1;
                state_d = ST_EXPAND;
            end
        end else if (hs) begin
            if (idx_q == NR) begin
                state_d = ST_IDLE;
            end else begin
                key_d   = next_key;
                idx_d   = idx_q + 4'd1;
                load_en = 1'b1;
            end
        end
    end

    // State, current round key and index registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.oRoundKey   = key_q;
    assign bus.oRoundIdx   = idx_q;
    assign bus.oKeyValid   = vld;
    assign bus.oBusy       = vld;
    assign bus.oFinalRound = vld && (idx_q == NR);

`ifdef AES_KEY_BUFFER_EN
    logic [127:0] bank_q [0:10];
    logic [127:0] bank_d [0:10];

    // Capture every round key into its slot as it is produced
    always_comb begin
        for (int i = 0; i < 11; i++) begin
            bank_d[i] = bank_q[i];
        end
        if (load_en) begin
            bank_d[idx_d] = key_d;
        end
    end

    // Round-key bank storage, cleared on reset
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < 11; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 11; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    assign bus.oRdKey = (bus.iRdIdx <= NR) ? bank_q[bus.iRdIdx] : '0;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand using FIPS-197 A.1 and all-zero-key round keys.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
// Covers reset, streaming, backpressure, ignored start, mid-run reset and back-to-back start.
module tb_aes_key_expand;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    aes_key_expand_if kif ();

    aes_key_expand dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] Z1 = 128'h62636363626363636263636362636363;
    logic [127:0] rk [0:10];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vld"},  kif.oKeyValid,   0);
        check({tag, "_busy"}, kif.oBusy,       0);
        check({tag, "_fin"},  kif.oFinalRound, 0);
    endtask

    initial begin
        rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst_n         = 1'b0;
        kif.iStart    = 1'b0;
        kif.iKey      = '0;
        kif.iKeyReady = 1'b0;
`ifdef AES_KEY_BUFFER_EN
        kif.iRdIdx    = 4'd0;
`endif

        // Reset state
        #12;
        check_idle("rst");
        check("rst_idx", kif.oRoundIdx, 0);
        check("rst_key", kif.oRoundKey, 0);
`ifdef AES_KEY_BUFFER_EN
        check("rst_rd", kif.oRdKey, 0);
`endif
        rst_n = 1'b1;
        step();
        check_idle("post_rst");

        // FIPS-197 stream with ready held high: 11 valid cycles, final only at 10
        kif.iKeyReady = 1'b1;
        kif.iStart    = 1'b1;
        kif.iKey      = K;
        step();
        kif.iStart = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            check("t1_vld",  kif.oKeyValid,   1);
            check("t1_busy", kif.oBusy,       1);
            check("t1_idx",  kif.oRoundIdx,   c);
            check("t1_fin",  kif.oFinalRound, (c == 10));
            check("t1_key",  kif.oRoundKey,   rk[c]);
            step();
        end
        check_idle("t1_end");
`ifdef AES_KEY_BUFFER_EN
        kif.iRdIdx = 4'd1;  #1; check("buf_rd1",  kif.oRdKey, rk[1]);
        kif.iRdIdx = 4'd10; #1; check("buf_rd10", kif.oRdKey, rk[10]);
        kif.iRdIdx = 4'd0;  #1; check("buf_rd0",  kif.oRdKey, K);
        kif.iRdIdx = 4'd15; #1; check("buf_rd15", kif.oRdKey, 0);
        step();
`endif

        // Backpressure at index 3 for five cycles
        kif.iStart = 1'b1;
        kif.iKey   = K;
        step();
        kif.iStart = 1'b0;
        repeat (3) step();
        check("t2_idx3", kif.oRoundIdx, 3);
        kif.iKeyReady = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t2_hold_idx", kif.oRoundIdx, 3);
            check("t2_hold_key", kif.oRoundKey, rk[3]);
            check("t2_hold_vld", kif.oKeyValid, 1);
        end
        kif.iKeyReady = 1'b1;
        step();
        check("t2_idx4", kif.oRoundIdx, 4);
        check("t2_key4", kif.oRoundKey, rk[4]);
        for (int c = 5; c <= 10; c++) begin
            step();
            check("t2_key", kif.oRoundKey, rk[c]);
        end
        check("t2_fin", kif.oFinalRound, 1);
        step();
        check_idle("t2_end");

        // Start with a different key at index 5 is ignored
        kif.iStart = 1'b1;
        kif.iKey   = K;
        step();
        kif.iStart = 1'b0;
        repeat (5) step();
        check("t3_idx5", kif.oRoundIdx, 5);
        kif.iStart = 1'b1;
        kif.iKey   = K2;
        step();
        kif.iStart = 1'b0;
        check("t3_idx6", kif.oRoundIdx, 6);
        check("t3_key6", kif.oRoundKey, rk[6]);
        repeat (4) step();
        check("t3_key10", kif.oRoundKey, rk[10]);
        check("t3_fin",   kif.oFinalRound, 1);
        step();
        check_idle("t3_end");
        step();
        check_idle("t3_noqueue");

        // Asynchronous reset at index 6, then restart with a new key
        kif.iStart = 1'b1;
        kif.iKey   = K;
        step();
        kif.iStart = 1'b0;
        repeat (6) step();
        check("t4_key6", kif.oRoundKey, rk[6]);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("t4_rst");
        check("t4_rst_idx", kif.oRoundIdx, 0);
        check("t4_rst_key", kif.oRoundKey, 0);
`ifdef AES_KEY_BUFFER_EN
        kif.iRdIdx = 4'd1;
        #0;
        check("t4_rst_rd", kif.oRdKey, 0);
`endif
        #1;
        rst_n = 1'b1;
        step();
        check_idle("t4_after");
        kif.iStart = 1'b1;
        kif.iKey   = K2;
        step();
        kif.iStart = 1'b0;
        check("t4_vld",  kif.oKeyValid, 1);
        check("t4_idx0", kif.oRoundIdx, 0);
        check("t4_key0", kif.oRoundKey, K2);
        repeat (10) step();
        check("t4_fin", kif.oFinalRound, 1);

        // Back-to-back: start during the round-10 handshake is ignored, next cycle accepted
        kif.iStart = 1'b1;
        kif.iKey   = '0;
        step();
        check_idle("t5_gap");
        step();
        kif.iStart = 1'b0;
        check("t5_busy", kif.oBusy,     1);
        check("t5_vld",  kif.oKeyValid, 1);
        check("t5_idx0", kif.oRoundIdx, 0);
        check("t5_key0", kif.oRoundKey, 0);
        step();
        check("t5_idx1", kif.oRoundIdx, 1);
        check("t5_key1", kif.oRoundKey, Z1);
        repeat (9) step();
        check("t5_fin", kif.oFinalRound, 1);
        step();
        check_idle("t5_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
